leaf_rx_demux: RTL and testbench
================================

# leaf_rx_demux

Receive-side stage of a leaf interface; sits directly downstream of the BFT leaf port and consumes the 49-bit packets it delivers on `din_leaf_bft2interface`. It decodes each valid packet's destination port and buffers the 32-bit payload in a per-port FIFO. Each FIFO presents a valid/ready stream to the operator inside the leaf. A one-cycle credit pulse is returned per consumed word so the upstream sender can pace traffic.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of operator input streams, legal range 1..16.
- `FIFO_DEPTH`, default 16: words per port FIFO; must be a power of 2, minimum 2.

Ports:
- `clk`, input, 1: the only clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `ap_start`, input, 1: enables packet acceptance.
- `din_leaf_bft2interface`, input, 49: packet from the BFT.
- `dout_data`, output, NUM_PORTS*32: payload of port p is `[32p+31:32p]`.
- `dout_valid`, output, NUM_PORTS: per-port word available.
- `dout_ready`, input, NUM_PORTS: per-port consumer ready.
- `credit_ret`, output, NUM_PORTS: one-cycle pulse per consumed word.
- `overflow`, output, 1: sticky; set when a packet was dropped because its FIFO was full.
- `drop_cnt`, output, 16: count of dropped packets; see Configuration.

## Operation
Packet format:
- `[48]`: valid.
- `[47:43]`: leaf address. Ignored here; routing is already done by the BFT.
- `[42:39]`: port index.
- `[38:32]`: reserved, ignored.
- `[31:0]`: payload.

Behaviour:
- **Input register.** The packet is registered every cycle, unconditionally.
- **Accept.** A registered packet is accepted when all of these hold: valid = 1, `ap_start` = 1 (sampled with the packet), and port index < NUM_PORTS. On acceptance the payload is written to FIFO[port].
- **ap_start low.** Valid packets are ignored silently: not written, not counted, no flag.
- **Bad port.** Valid packet with port index ≥ NUM_PORTS while `ap_start` = 1: packet dropped, `drop_cnt` incremented, `overflow` not set.
- **FIFO full.** Write to a full FIFO with no pop in the same cycle: packet dropped, `overflow` set, `drop_cnt` incremented.
- **Full with pop.** Write to a full FIFO with a pop in the same cycle: the write is accepted and the occupancy stays at FIFO_DEPTH.
- **FIFO structure.** Binary read/write pointers of log2(FIFO_DEPTH) bits that wrap naturally, plus a count register of log2(FIFO_DEPTH)+1 bits.
- **Stream output.** `dout_valid[p]` = (count[p] != 0). `dout_data` is the head word.
- **Pop.** A pop occurs when `dout_valid[p]` and `dout_ready[p]` are both high.
- **Credit.** `credit_ret[p]` is a registered pulse asserted in the cycle after each pop. Back-to-back pops give a continuously high `credit_ret`.
- **Sticky flag.** `overflow` clears only on `reset`.
- **Counter saturation.** `drop_cnt` saturates at 0xFFFF; it does not wrap.

## Timing
- Reset values: `dout_valid` = 0, `dout_data` = 0, `credit_ret` = 0, `overflow` = 0, `drop_cnt` = 0. All FIFOs empty, pointers and counts 0, input register cleared.
- Reset asserted mid-operation discards all buffered words. No credits are issued for discarded words.
- Latency: packet present at the input in cycle N gives `dout_valid` = 1 with its payload in cycle N+2, provided the FIFO was empty. There is no empty-FIFO bypass.
- Sustained throughput: one accepted packet per cycle, and independently one pop per cycle per port.
- `overflow` and `drop_cnt` update in cycle N+2 for a packet presented in cycle N.
- `credit_ret` for a pop in cycle M is asserted in cycle M+1.
- Simultaneous push and pop on an empty FIFO cannot occur, because valid is 0 when the FIFO is empty.

## Configuration
- `LEAF_RX_DROP_CNT_EN` defined: the 16-bit saturating `drop_cnt` register is built as described above.
- `LEAF_RX_DROP_CNT_EN` undefined: no counter logic is built and `drop_cnt` is tied to 16'h0000. `overflow` is present in both builds.

## Test plan
- **Reset values.** Assert reset for 2 cycles, then release. Every output is 0.
- **Single packet.** With `ap_start` = 1, drive one packet: port 2, payload 0xDEADBEEF, in cycle N. Required: `dout_valid[2]` = 1 in cycle N+2 with `dout_data[95:64]` = 0xDEADBEEF. With `dout_ready[2]` = 1, `credit_ret[2]` pulses exactly once.
- **Overflow.** Hold `dout_ready[0]` = 0 and send 17 packets to port 0 with FIFO_DEPTH = 16. Required: `overflow` = 1, `drop_cnt` = 1. Draining yields 16 words in the order sent.
- **Full plus pop.** Fill port 1 to 16 words. In one cycle, write a new packet while popping. Required: the write is accepted, occupancy stays at 16, `overflow` stays 0, the 17th word is eventually read out.
- **Bad port and ap_start low.** With NUM_PORTS = 4, send a packet with port index 7: `drop_cnt` = 1, `overflow` = 0. With `ap_start` = 0, send a packet to port 0: nothing is buffered and `drop_cnt` is unchanged.
- **Reset mid-stream.** Buffer 5 words on port 3, then assert reset. Required: `dout_valid` = 0 after reset, and no `credit_ret` pulse is issued for the flushed words.

Source files
------------

// File: rtl/leaf_rx_demux.sv
// rtl/leaf_rx_demux.sv - BFT leaf receive demux into per-port FIFOs with credit return
// Optional feature: define LEAF_RX_DROP_CNT_EN to build the saturating drop_cnt register.
module leaf_rx_demux #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ap_start,
  input  logic [48:0]               din_leaf_bft2interface,
  output logic [NUM_PORTS*32-1:0]   dout_data,
  output logic [NUM_PORTS-1:0]      dout_valid,
  input  logic [NUM_PORTS-1:0]      dout_ready,
  output logic [NUM_PORTS-1:0]      credit_ret,
  output logic                      overflow,
  output logic [15:0]               drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
  localparam logic [4:0]    NUM_PORTS_L = 5'(NUM_PORTS);

  // Registered packet fields; leaf address and reserved bits are not kept.
  logic        pkt_valid_q;
  logic        start_q;
  logic [3:0]  port_q;
  logic [31:0] payload_q;

  // Per-port FIFO storage and bookkeeping.
  logic [31:0]   mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [NUM_PORTS];
  logic [AW-1:0] rd_ptr_q [NUM_PORTS];
  logic [CW-1:0] cnt_q    [NUM_PORTS];

  logic [NUM_PORTS-1:0] push_req;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] wr_en;
  logic [NUM_PORTS-1:0] credit_q;
  logic                 overflow_q;
  logic                 bad_port;
  logic                 drop_full;
  logic                 drop;

  logic unused_pkt_bits;
  assign unused_pkt_bits = &{1'b0, din_leaf_bft2interface[47:43], din_leaf_bft2interface[38:32]};

  // Input register: captures the packet and ap_start together every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_valid_q <= 1'b0;
      start_q     <= 1'b0;
      port_q      <= 4'h0;
      payload_q   <= 32'h0;
    end else begin
      pkt_valid_q <= din_leaf_bft2interface[48];
      start_q     <= ap_start;
      port_q      <= din_leaf_bft2interface[42:39];
      payload_q   <= din_leaf_bft2interface[31:0];
    end
  end

  // Stream outputs: head word of each non-empty FIFO, zero when empty.
  always_comb begin
    dout_valid = '0;
    dout_data  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dout_valid[p]        = (cnt_q[p] != '0);
      dout_data[32*p +: 32] = dout_valid[p] ? mem_q[p][rd_ptr_q[p]] : 32'h0;
    end
  end

  // Decode the registered packet into per-port writes, pops and drop events.
  always_comb begin
    push_req = '0;
    full     = '0;
    pop      = '0;
    wr_en    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      full[p]     = (cnt_q[p] == FULL_CNT);
      pop[p]      = dout_valid[p] & dout_ready[p];
      push_req[p] = pkt_valid_q & start_q & ({1'b0, port_q} == 5'(p));
      // A pop in the same cycle frees the slot the write needs.
      wr_en[p]    = push_req[p] & (~full[p] | pop[p]);
    end
    bad_port  = pkt_valid_q & start_q & ({1'b0, port_q} >= NUM_PORTS_L);
    drop_full = |(push_req & full & ~pop);
    drop      = bad_port | drop_full;
  end

  // FIFO payload storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en[p]) begin
        mem_q[p][wr_ptr_q[p]] <= payload_q;
      end
    end
  end

  // Pointers, occupancy counts, credit pulses and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en[p]) begin
          wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
        end
        if (pop[p]) begin
          rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
        end
        case ({wr_en[p], pop[p]})
          2'b10:   cnt_q[p] <= cnt_q[p] + CW'(1);
          2'b01:   cnt_q[p] <= cnt_q[p] - CW'(1);
          default: cnt_q[p] <= cnt_q[p];
        endcase
      end
      credit_q <= pop;
      if (drop_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign credit_ret = credit_q;
  assign overflow   = overflow_q;

`ifdef LEAF_RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped packets (bad port or full FIFO).
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 16'h0000;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'h0001;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_leaf_rx_demux.sv
// tb/tb_leaf_rx_demux.sv - directed table-driven bench for leaf_rx_demux
module tb_leaf_rx_demux;

  localparam int NP = 4;
`ifdef LEAF_RX_DROP_CNT_EN
  localparam logic DROP_EN = 1'b1;
`else
  localparam logic DROP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              ap_start;
  logic [48:0]       din;
  logic [NP*32-1:0]  dout_data;
  logic [NP-1:0]     dout_valid;
  logic [NP-1:0]     dout_ready;
  logic [NP-1:0]     credit_ret;
  logic              overflow;
  logic [15:0]       drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ap;
    logic        vld;
    logic [3:0]  port;
    logic [31:0] payload;
    logic [3:0]  exp_valid;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  leaf_rx_demux #(.NUM_PORTS(NP), .FIFO_DEPTH(16)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ap_start               (ap_start),
    .din_leaf_bft2interface (din),
    .dout_data              (dout_data),
    .dout_valid             (dout_valid),
    .dout_ready             (dout_ready),
    .credit_ret             (credit_ret),
    .overflow               (overflow),
    .drop_cnt               (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] pkt(input logic v, input logic [3:0] port, input logic [31:0] pl);
    return {v, 5'h15, port, 7'h2A, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    ap_start   = 1'b0;
    din        = '0;
    dout_ready = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd2, 32'hDEADBEEF, 4'b0100, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 4'd0, 32'h12345678, 4'b0001, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 4'd3, 32'hA5A5A5A5, 4'b1000, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 4'd7, 32'h77777777, 4'b0000, 16'd1};
    vecs[4] = '{1'b0, 1'b1, 4'd0, 32'h0BADF00D, 4'b0000, 16'd1};
    vecs[5] = '{1'b1, 1'b1, 4'd1, 32'hCAFEF00D, 4'b0010, 16'd1};
    vecs[6] = '{1'b1, 1'b0, 4'd1, 32'h55AA55AA, 4'b0000, 16'd1};

    reset      = 1'b1;
    ap_start   = 1'b0;
    din        = '0;
    dout_ready = '0;
    @(negedge clk);
    do_reset();
    tick();
    check("reset dout_valid", 32'(dout_valid), 32'h0);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("reset dout_data[%0d]", p), dout_data[32*p +: 32], 32'h0);
    end
    check("reset credit_ret", 32'(credit_ret), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset drop_cnt", 32'(drop_cnt), 32'h0);

    // Single-packet vectors: latency, routing, drop rules and one credit per pop.
    for (int i = 0; i < 7; i++) begin
      ap_start = vecs[i].ap;
      din      = pkt(vecs[i].vld, vecs[i].port, vecs[i].payload);
      tick();
      ap_start = 1'b0;
      din      = '0;
      check($sformatf("vec%0d latency valid", i), 32'(dout_valid), 32'h0);
      tick();
      check($sformatf("vec%0d valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid != 4'b0000) begin
        check($sformatf("vec%0d data", i), dout_data[32*vecs[i].port +: 32], vecs[i].payload);
      end
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'h0);
      check($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), DROP_EN ? 32'(vecs[i].exp_drop) : 32'h0);
      dout_ready = 4'hF;
      tick();
      dout_ready = 4'h0;
      check($sformatf("vec%0d credit", i), 32'(credit_ret), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d drained", i), 32'(dout_valid), 32'h0);
      tick();
      check($sformatf("vec%0d credit end", i), 32'(credit_ret), 32'h0);
    end

    // Overflow: 17 packets into a 16-deep FIFO with no consumer.
    do_reset();
    ap_start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din = pkt(1'b1, 4'd0, 32'h100 + 32'(i));
      tick();
    end
    din = '0;
    tick();
    check("ovf overflow", 32'(overflow), 32'h1);
    check("ovf drop_cnt", 32'(drop_cnt), DROP_EN ? 32'h1 : 32'h0);
    dout_ready = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf valid%0d", k), 32'(dout_valid[0]), 32'h1);
      check($sformatf("ovf data%0d", k), dout_data[31:0], 32'h100 + 32'(k));
      if (k > 0) begin
        check($sformatf("ovf credit%0d", k), 32'(credit_ret[0]), 32'h1);
      end
      tick();
    end
    check("ovf empty", 32'(dout_valid[0]), 32'h0);
    check("ovf last credit", 32'(credit_ret[0]), 32'h1);
    dout_ready = '0;
    tick();
    check("ovf credit off", 32'(credit_ret), 32'h0);
    check("ovf sticky", 32'(overflow), 32'h1);

    // Full plus pop: write into a full FIFO in the same cycle as a pop.
    do_reset();
    ap_start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = pkt(1'b1, 4'd1, 32'h200 + 32'(i));
      tick();
    end
    din = pkt(1'b1, 4'd1, 32'h2FF);
    tick();
    din        = '0;
    dout_ready = 4'b0010;
    check("fp head", dout_data[63:32], 32'h200);
    tick();
    dout_ready = '0;
    check("fp credit", 32'(credit_ret[1]), 32'h1);
    tick();
    check("fp overflow", 32'(overflow), 32'h0);
    check("fp drop_cnt", 32'(drop_cnt), 32'h0);
    dout_ready = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("fp valid%0d", k), 32'(dout_valid[1]), 32'h1);
      check($sformatf("fp data%0d", k), dout_data[63:32], (k < 15) ? 32'h201 + 32'(k) : 32'h2FF);
      tick();
    end
    check("fp empty", 32'(dout_valid[1]), 32'h0);
    dout_ready = '0;

    // Reset mid-stream: buffered words vanish and earn no credit.
    do_reset();
    ap_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = pkt(1'b1, 4'd3, 32'h300 + 32'(i));
      tick();
    end
    din = '0;
    tick();
    check("rst buffered valid", 32'(dout_valid), 32'h8);
    check("rst buffered data", dout_data[127:96], 32'h300);
    reset      = 1'b1;
    dout_ready = 4'b1000;
    tick();
    check("rst valid", 32'(dout_valid), 32'h0);
    check("rst credit", 32'(credit_ret), 32'h0);
    reset = 1'b0;
    tick();
    check("rst valid after", 32'(dout_valid), 32'h0);
    check("rst credit after", 32'(credit_ret), 32'h0);
    tick();
    check("rst credit later", 32'(credit_ret), 32'h0);
    dout_ready = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
